// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix data loader: default geometry, base
// addresses and the loader FSM state encoding.
package matrix_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_A_WORDS   = 4;
    localparam int DEF_ROW_WORDS = 7;
    localparam int DEF_N_ROWS    = 28;
    localparam int DEF_A_BASE    = 0;
    localparam int DEF_ROW_BASE  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_A   = 3'd1,
        ST_LOAD_ROW = 3'd2,
        ST_WAIT_BUF = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_data_loader_if.sv
// Controller/SRAM/ALU-facing signal bundle of the matrix data loader.
// The loader is the slave; the surrounding controller and memory are the master.
interface matrix_data_loader_if
    import matrix_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int A_WORDS   = DEF_A_WORDS,
    parameter int ROW_WORDS = DEF_ROW_WORDS
);
    logic                          load_A_en;
    logic                          load_en;
    logic                          row_finish;
    logic                          mem_ry;
    logic [DATA_W-1:0]             mem_rdata;
    logic                          mem_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          load_A_done;
    logic                          load_done;
    logic [DATA_W*A_WORDS-1:0]     a_data;
    logic [DATA_W*ROW_WORDS-1:0]   row_data;
    logic                          row_valid;

    modport slave (
        input  load_A_en, load_en, row_finish, mem_ry, mem_rdata,
        output mem_en, mem_addr, load_A_done, load_done, a_data, row_data, row_valid
    );

    modport master (
        output load_A_en, load_en, row_finish, mem_ry, mem_rdata,
        input  mem_en, mem_addr, load_A_done, load_done, a_data, row_data, row_valid
    );

endinterface

// File: rtl/row_pingpong_buf.sv
// Two-entry row buffer: the loader fills buffer[wr_sel] word by word while the
// ALU consumes buffer[rd_sel]; full flags gate both sides.
module row_pingpong_buf #(
    parameter int DATA_W    = 32,
    parameter int ROW_WORDS = 7,
    parameter int IDX_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        we,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        commit,
    input  logic                        row_finish,
    output logic                        wr_sel,
    output logic [1:0]                  full_nxt,
    output logic                        row_valid,
    output logic [DATA_W*ROW_WORDS-1:0] row_data
);

    logic [DATA_W*ROW_WORDS-1:0] mem_r [2];
    logic [1:0]                  full_r;
    logic                        wr_sel_r;
    logic                        rd_sel_r;
    logic                        rel_s;
    logic [1:0]                  full_nxt_s;

    assign rel_s = row_finish & full_r[rd_sel_r];

    // Next-cycle full flags; a release and a commit on different buffers both apply
    always_comb begin
        full_nxt_s = full_r;
        if (clr) begin
            full_nxt_s = 2'b00;
        end else begin
            if (commit) begin
                full_nxt_s[wr_sel_r] = 1'b1;
            end else begin
                full_nxt_s[wr_sel_r] = full_r[wr_sel_r];
            end
            if (rel_s) begin
                full_nxt_s[rd_sel_r] = 1'b0;
            end else begin
                full_nxt_s[rd_sel_r] = full_nxt_s[rd_sel_r];
            end
        end
    end

    // Full flags and buffer selectors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r   <= 2'b00;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
        end else begin
            full_r <= full_nxt_s;
            if (clr) begin
                wr_sel_r <= 1'b0;
                rd_sel_r <= 1'b0;
            end else begin
                if (commit) begin
                    wr_sel_r <= ~wr_sel_r;
                end
                if (rel_s) begin
                    rd_sel_r <= ~rd_sel_r;
                end
            end
        end
    end

    // Row storage write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (we && !clr) begin
            mem_r[wr_sel_r][int'(wr_idx)*DATA_W +: DATA_W] <= wr_data;
        end
    end

    assign wr_sel    = wr_sel_r;
    assign full_nxt  = full_nxt_s;
    assign row_valid = full_r[rd_sel_r];
    assign row_data  = mem_r[rd_sel_r];

endmodule

// File: rtl/matrix_data_loader.sv
// Memory-side responder to the matrix controller: fetches coefficient block A,
// then streams image rows from SRAM into a ping-pong buffer for the ALU.
module matrix_data_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int A_WORDS   = DEF_A_WORDS,
    parameter int ROW_WORDS = DEF_ROW_WORDS,
    parameter int N_ROWS    = DEF_N_ROWS,
    parameter int A_BASE    = DEF_A_BASE,
    parameter int ROW_BASE  = DEF_ROW_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_data_loader_if.slave  bus
);

    localparam int CNT_W  = $clog2(max_int(A_WORDS, ROW_WORDS) + 1);
    localparam int RIDX_W = $clog2(N_ROWS + 1);

    state_e                    state_r;
    state_e                    state_s;
    logic [CNT_W-1:0]          issue_cnt_r;
    logic [CNT_W-1:0]          cap_cnt_r;
    logic [CNT_W-1:0]          words_s;
    logic [RIDX_W-1:0]         row_idx_r;
    logic [RIDX_W-1:0]         row_idx_inc_s;
    logic                      cap_pend_r;
    logic                      mem_en_r;
    logic [ADDR_W-1:0]         mem_addr_r;
    logic [ADDR_W-1:0]         start_addr_s;
    logic                      load_A_done_r;
    logic                      load_done_r;
    logic [DATA_W*A_WORDS-1:0] a_data_r;
    logic                      accept_s;
    logic                      abort_s;
    logic                      capture_s;
    logic                      last_cap_s;
    logic                      a_last_s;
    logic                      row_last_s;
    logic                      start_s;
    logic                      buf_we_s;
    logic                      wr_sel_s;
    logic [1:0]                full_nxt_s;

    // Row start address wraps modulo 2^ADDR_W by truncation
    function automatic logic [ADDR_W-1:0] row_addr(input logic [RIDX_W-1:0] idx);
        logic [31:0] a;
        a = 32'(ROW_BASE) + 32'(idx) * 32'(ROW_WORDS);
        return a[ADDR_W-1:0];
    endfunction

    assign accept_s      = mem_en_r & bus.mem_ry;
    assign abort_s       = (state_r != ST_IDLE) & ~bus.load_en;
    assign capture_s     = cap_pend_r & ~abort_s;
    assign last_cap_s    = capture_s & (cap_cnt_r == (words_s - CNT_W'(1)));
    assign a_last_s      = last_cap_s & (state_r == ST_LOAD_A);
    assign row_last_s    = last_cap_s & (state_r == ST_LOAD_ROW);
    assign buf_we_s      = capture_s & (state_r == ST_LOAD_ROW);
    assign row_idx_inc_s = row_idx_r + RIDX_W'(1);

    // Burst length of the current fetch phase
    always_comb begin
        if (state_r == ST_LOAD_A) begin
            words_s = CNT_W'(A_WORDS);
        end else begin
            words_s = CNT_W'(ROW_WORDS);
        end
    end

    // Next-state and fetch-start decode
    always_comb begin
        state_s      = state_r;
        start_s      = 1'b0;
        start_addr_s = '0;
        if (abort_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load_A_en) begin
                        state_s      = ST_LOAD_A;
                        start_s      = 1'b1;
                        start_addr_s = ADDR_W'(A_BASE);
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD_A: begin
                    if (a_last_s) begin
                        state_s      = ST_LOAD_ROW;
                        start_s      = 1'b1;
                        start_addr_s = row_addr(row_idx_r);
                    end else begin
                        state_s = ST_LOAD_A;
                    end
                end
                ST_LOAD_ROW: begin
                    if (!row_last_s) begin
                        state_s = ST_LOAD_ROW;
                    end else if (row_idx_inc_s == RIDX_W'(N_ROWS)) begin
                        state_s = ST_DONE;
                    end else if (full_nxt_s[~wr_sel_s]) begin
                        state_s = ST_WAIT_BUF;
                    end else begin
                        state_s      = ST_LOAD_ROW;
                        start_s      = 1'b1;
                        start_addr_s = row_addr(row_idx_inc_s);
                    end
                end
                ST_WAIT_BUF: begin
                    if (!full_nxt_s[wr_sel_s]) begin
                        state_s      = ST_LOAD_ROW;
                        start_s      = 1'b1;
                        start_addr_s = row_addr(row_idx_r);
                    end else begin
                        state_s = ST_WAIT_BUF;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read issue, capture tracking and completion pulses; abort drops in-flight data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_r      <= 1'b0;
            mem_addr_r    <= '0;
            issue_cnt_r   <= '0;
            cap_cnt_r     <= '0;
            cap_pend_r    <= 1'b0;
            row_idx_r     <= '0;
            load_A_done_r <= 1'b0;
            load_done_r   <= 1'b0;
        end else if (abort_s) begin
            mem_en_r      <= 1'b0;
            issue_cnt_r   <= '0;
            cap_cnt_r     <= '0;
            cap_pend_r    <= 1'b0;
            row_idx_r     <= '0;
            load_A_done_r <= 1'b0;
            load_done_r   <= 1'b0;
        end else begin
            cap_pend_r    <= accept_s;
            load_A_done_r <= a_last_s;
            load_done_r   <= row_last_s;
            if (start_s) begin
                mem_en_r    <= 1'b1;
                mem_addr_r  <= start_addr_s;
                issue_cnt_r <= '0;
            end else if (accept_s) begin
                if (issue_cnt_r == (words_s - CNT_W'(1))) begin
                    mem_en_r    <= 1'b0;
                    issue_cnt_r <= '0;
                end else begin
                    issue_cnt_r <= issue_cnt_r + CNT_W'(1);
                    mem_addr_r  <= mem_addr_r + ADDR_W'(1);
                end
            end
            if (capture_s) begin
                if (last_cap_s) begin
                    cap_cnt_r <= '0;
                end else begin
                    cap_cnt_r <= cap_cnt_r + CNT_W'(1);
                end
            end
            if (row_last_s) begin
                row_idx_r <= row_idx_inc_s;
            end
        end
    end

    // Coefficient block; kept across an aborted session
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_data_r <= '0;
        end else if (capture_s && (state_r == ST_LOAD_A)) begin
            a_data_r[int'(cap_cnt_r)*DATA_W +: DATA_W] <= bus.mem_rdata;
        end
    end

    row_pingpong_buf #(
        .DATA_W    (DATA_W),
        .ROW_WORDS (ROW_WORDS),
        .IDX_W     (CNT_W)
    ) u_row_buf (
        .clk        (clk),
        .rst        (rst),
        .clr        (abort_s),
        .we         (buf_we_s),
        .wr_idx     (cap_cnt_r),
        .wr_data    (bus.mem_rdata),
        .commit     (row_last_s),
        .row_finish (bus.row_finish),
        .wr_sel     (wr_sel_s),
        .full_nxt   (full_nxt_s),
        .row_valid  (bus.row_valid),
        .row_data   (bus.row_data)
    );

    assign bus.mem_en      = mem_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.load_A_done = load_A_done_r;
    assign bus.load_done   = load_done_r;
    assign bus.a_data      = a_data_r;

endmodule

// File: tb/tb_matrix_data_loader.sv
// Directed bench for matrix_data_loader; SRAM model returns word k = k.
module tb_matrix_data_loader;
    import matrix_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;
    localparam int NA = DEF_A_WORDS;
    localparam int RW = DEF_ROW_WORDS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matrix_data_loader_if #(.DATA_W(DW), .ADDR_W(AW), .A_WORDS(NA), .ROW_WORDS(RW)) bus();

    matrix_data_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int row_q_base = 0;
    int frame_done = 0;
    logic [AW-1:0] acc_q [$];

    // SRAM model and accepted-address log
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_ry) begin
            acc_q.push_back(bus.mem_addr);
            bus.mem_rdata <= DW'(bus.mem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*RW-1:0] exp_row(input int first);
        logic [DW*RW-1:0] r;
        for (int j = 0; j < RW; j++) r[j*DW +: DW] = DW'(first + j);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.load_A_en = 1'b0; bus.load_en = 1'b0; bus.row_finish = 1'b0; bus.mem_ry = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.mem_en, bus.load_A_done, bus.load_done, bus.row_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {bus.mem_en, bus.load_A_done, bus.load_done, bus.row_valid});
        end
        checks++;
        if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.mem_addr); end
        checks++;
        if (bus.a_data !== 128'd0 || bus.row_data !== 224'd0) begin errors++; $display("FAIL reset_data got nonzero want 0"); end
        checks++;
        if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_r); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_a();
        int t_first = -1;
        int t_done = -1;
        int base;
        int bad = 0;
        base = acc_q.size();
        row_q_base = base + NA;
        bus.load_en = 1'b1; bus.load_A_en = 1'b1;
        for (int c = 0; c < 30 && t_done < 0; c++) begin
            tick();
            if (bus.mem_en && t_first < 0) t_first = c;
            if (bus.load_A_done) t_done = c;
        end
        checks++;
        if (t_done < 0) begin errors++; $display("FAIL load_a_timeout got none want load_A_done"); end
        checks++;
        if (t_done - t_first !== 5) begin errors++; $display("FAIL load_a_latency got %0d want 5", t_done - t_first); end
        if (acc_q.size() < base + NA) bad = 1;
        else for (int i = 0; i < NA; i++) if (acc_q[base+i] !== AW'(i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL load_a_addrs got %0d bad want 0", bad); end
        checks++;
        if (bus.a_data !== {32'd3, 32'd2, 32'd1, 32'd0}) begin errors++; $display("FAIL a_data got %h want 3,2,1,0", bus.a_data); end
        tick();
        bus.load_A_en = 1'b0;
        checks++;
        if (bus.load_A_done !== 1'b0) begin errors++; $display("FAIL load_a_pulse got %b want 0", bus.load_A_done); end
    endtask

    task automatic test_rows_no_finish();
        int t23 = -1;
        int tdone2 = -1;
        int pulses = 0;
        int bad = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.mem_en && bus.mem_addr == 10'd23 && t23 < 0) t23 = c;
            if (bus.load_done) begin
                pulses++;
                if (pulses == 2) tdone2 = c;
            end
        end
        frame_done = pulses;
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL rows_pulses got %0d want 2", pulses); end
        checks++;
        if (tdone2 - t23 !== 8) begin errors++; $display("FAIL row_latency got %0d want 8", tdone2 - t23); end
        if (acc_q.size() != row_q_base + 14) bad = 100;
        else for (int i = 0; i < 14; i++) if (acc_q[row_q_base+i] !== AW'(16 + i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rows_addrs got %0d bad want 0", bad); end
        checks++;
        if (bus.row_valid !== 1'b1 || bus.row_data !== exp_row(16)) begin
            errors++; $display("FAIL row0_data got v=%b %h want row 16..22", bus.row_valid, bus.row_data);
        end
        checks++;
        if (dut.state_r !== ST_WAIT_BUF || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL wait_buf got state=%0d mem_en=%b want WAIT_BUF,0", dut.state_r, bus.mem_en);
        end
    endtask

    task automatic test_row_finish();
        bus.row_finish = 1'b1;
        tick();
        bus.row_finish = 1'b0;
        checks++;
        if (bus.row_valid !== 1'b1 || bus.row_data !== exp_row(23)) begin
            errors++; $display("FAIL row1_data got v=%b %h want row 23..29", bus.row_valid, bus.row_data);
        end
        checks++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'd30}) begin
            errors++; $display("FAIL row2_start got en=%b addr=%0d want 1,30", bus.mem_en, bus.mem_addr);
        end
    endtask

    task automatic test_stall();
        int s_base;
        int at_done = -1;
        int hold_bad = 0;
        int bad = 0;
        logic stalled;
        logic [AW-1:0] saddr;
        s_base = acc_q.size();
        for (int c = 0; c < 80 && at_done < 0; c++) begin
            bus.mem_ry = (c % 2 == 0) ? 1'b0 : 1'b1;
            stalled = bus.mem_en && !bus.mem_ry;
            saddr = bus.mem_addr;
            tick();
            if (stalled && (!bus.mem_en || bus.mem_addr !== saddr)) hold_bad++;
            if (bus.load_done) at_done = acc_q.size() - s_base;
        end
        bus.mem_ry = 1'b1;
        frame_done++;
        checks++;
        if (at_done !== 7) begin errors++; $display("FAIL stall_captures got %0d want 7", at_done); end
        checks++;
        if (hold_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d want 0", hold_bad); end
        if (acc_q.size() < s_base + RW) bad = 100;
        else for (int i = 0; i < RW; i++) if (acc_q[s_base+i] !== AW'(30 + i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stall_addrs got %0d bad want 0", bad); end
        tick();
        checks++;
        if (dut.state_r !== ST_WAIT_BUF) begin errors++; $display("FAIL stall_wait got %0d want WAIT_BUF", dut.state_r); end
        bus.row_finish = 1'b1;
        tick();
        bus.row_finish = 1'b0;
        checks++;
        if (bus.row_data !== exp_row(30)) begin errors++; $display("FAIL row2_data got %h want row 30..36", bus.row_data); end
    endtask

    task automatic test_full_frame();
        int bad = 0;
        int n;
        int reached = 0;
        for (int c = 0; c < 2000 && reached == 0; c++) begin
            bus.row_finish = (c % 30 == 29) ? 1'b1 : 1'b0;
            tick();
            if (bus.load_done) frame_done++;
            if (dut.state_r == ST_DONE) reached = 1;
        end
        bus.row_finish = 1'b0;
        checks++;
        if (reached !== 1) begin errors++; $display("FAIL frame_timeout got none want DONE"); end
        checks++;
        if (frame_done !== 28) begin errors++; $display("FAIL frame_pulses got %0d want 28", frame_done); end
        n = acc_q.size();
        if (n - row_q_base != 196) bad = 100;
        else for (int i = 0; i < RW; i++) if (acc_q[n-RW+i] !== AW'(205 + i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL last_row_addrs got %0d bad want 0", bad); end
        repeat (5) tick();
        checks++;
        if (acc_q.size() !== n || bus.mem_en !== 1'b0 || dut.state_r !== ST_DONE) begin
            errors++; $display("FAIL done_quiet got reads=%0d en=%b want %0d,0", acc_q.size(), bus.mem_en, n);
        end
        bus.load_en = 1'b0;
        tick();
        checks++;
        if (dut.state_r !== ST_IDLE || bus.row_valid !== 1'b0) begin
            errors++; $display("FAIL done_exit got state=%0d v=%b want IDLE,0", dut.state_r, bus.row_valid);
        end
    endtask

    task automatic test_abort();
        int hit = 0;
        int late = 0;
        int r0;
        int bad = 0;
        int got;
        bus.load_en = 1'b1; bus.load_A_en = 1'b1;
        for (int c = 0; c < 600 && hit == 0; c++) begin
            bus.row_finish = (dut.state_r == ST_WAIT_BUF) ? 1'b1 : 1'b0;
            tick();
            if (bus.load_A_done) bus.load_A_en = 1'b0;
            if (bus.mem_en && bus.mem_addr == 10'd54) hit = 1;
        end
        bus.row_finish = 1'b0;
        checks++;
        if (hit !== 1) begin errors++; $display("FAIL abort_reach got none want addr 54"); end
        bus.load_en = 1'b0;
        tick();
        checks++;
        if (bus.mem_en !== 1'b0 || bus.row_valid !== 1'b0 || dut.state_r !== ST_IDLE) begin
            errors++; $display("FAIL abort_state got en=%b v=%b st=%0d want 0,0,IDLE", bus.mem_en, bus.row_valid, dut.state_r);
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.load_done || bus.mem_en) late++;
            tick();
        end
        checks++;
        if (late !== 0) begin errors++; $display("FAIL abort_quiet got %0d want 0", late); end
        checks++;
        if (bus.a_data !== {32'd3, 32'd2, 32'd1, 32'd0}) begin errors++; $display("FAIL abort_a_kept got %h want 3,2,1,0", bus.a_data); end
        r0 = acc_q.size();
        bus.load_en = 1'b1; bus.load_A_en = 1'b1;
        hit = 0;
        for (int c = 0; c < 60 && hit == 0; c++) begin
            tick();
            if (bus.load_A_done) bus.load_A_en = 1'b0;
            if (bus.load_done) hit = 1;
        end
        checks++;
        if (hit !== 1) begin errors++; $display("FAIL restart_timeout got none want load_done"); end
        got = acc_q.size() - r0;
        if (got < NA + RW) bad = 100;
        else begin
            for (int i = 0; i < NA; i++) if (acc_q[r0+i] !== AW'(i)) bad++;
            for (int i = 0; i < RW; i++) if (acc_q[r0+NA+i] !== AW'(16 + i)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL restart_addrs got %0d bad want 0", bad); end
        checks++;
        if (bus.row_valid !== 1'b1 || bus.row_data !== exp_row(16)) begin
            errors++; $display("FAIL restart_row got v=%b %h want row 16..22", bus.row_valid, bus.row_data);
        end
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_en, bus.load_A_done, bus.load_done, bus.row_valid} !== 4'b0000 || dut.state_r !== ST_IDLE) begin
            errors++; $display("FAIL async_reset got flags=%b st=%0d want 0000,IDLE",
                {bus.mem_en, bus.load_A_done, bus.load_done, bus.row_valid}, dut.state_r);
        end
        checks++;
        if (bus.a_data !== 128'd0 || bus.row_data !== 224'd0) begin errors++; $display("FAIL async_reset_data got nonzero want 0"); end
        bus.load_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_a();
        test_rows_no_finish();
        test_row_finish();
        test_stall();
        test_full_frame();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_data_loader.md
Name: matrix_data_loader

Overview:
- Memory-side responder to the matrix controller's load handshake.
- On load_A_en, fetches the coefficient block A from SRAM and pulses load_A_done.
- On load_en, fetches image rows into a ping-pong buffer, presenting each full row to the ALU and pulsing load_done per row.
- Buffers are released by row_finish; loading stalls while both buffers are full.

Parameters:
DATA_W, 32, memory word width
ADDR_W, 10, memory address width
A_WORDS, 4, words in coefficient block A
ROW_WORDS, 7, words per row (28 bytes, one per ALU shift)
N_ROWS, 28, rows per frame
A_BASE, 0, word address of A
ROW_BASE, 16, word address of row 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
load_A_en  in  1  controller requests A load (level)
load_en  in  1  controller load session active (level); low outside a session
row_finish  in  1  ALU finished consuming current row (1-cycle pulse)
mem_ry  in  1  SRAM accepts a read this cycle
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after an accepted read
mem_en  out  1  read request
mem_addr  out  ADDR_W  read word address
load_A_done  out  1  1-cycle pulse, A block captured
load_done  out  1  1-cycle pulse, one row captured
a_data  out  DATA_W*A_WORDS  A block, word 0 in LSBs
row_data  out  DATA_W*ROW_WORDS  current read-side row, word 0 in LSBs
row_valid  out  1  row_data holds an unconsumed row

Behaviour:
- Reset values: all outputs 0, state IDLE, both buffers empty, wr_sel = rd_sel = 0, row_idx = 0.
- States:
  - IDLE -> LOAD_A when load_A_en = 1.
  - LOAD_A -> LOAD_ROW after the last A word is captured.
  - LOAD_ROW -> DONE when row_idx reaches N_ROWS; -> WAIT_BUF if the next write buffer is still full; otherwise stays in LOAD_ROW for the next row.
  - WAIT_BUF -> LOAD_ROW when the write buffer is freed.
  - DONE -> IDLE when load_en = 0.
- Reads:
  - A read is accepted when mem_en & mem_ry.
  - Issue counter advances only on acceptance; mem_addr holds while mem_ry = 0.
  - Reads are issued back-to-back. A separate capture counter stores mem_rdata one cycle after each accepted read.
- Addresses:
  - A word i: A_BASE + i.
  - Row r word j: ROW_BASE + r*ROW_WORDS + j, computed modulo 2^ADDR_W.
- Completion pulses:
  - load_A_done is registered, high the cycle after the final A capture.
  - With mem_ry held at 1, load_A_done is high A_WORDS+1 cycles after the first A mem_en.
  - load_done follows the same rule: ROW_WORDS+1 cycles after the first mem_en of that row.
  - On load_done: mark buffer[wr_sel] full, toggle wr_sel, increment row_idx.
- Read side:
  - row_valid = full[rd_sel]; row_data = buffer[rd_sel].
  - row_finish with row_valid = 1: clear full[rd_sel], toggle rd_sel.
  - row_finish with row_valid = 0: ignored.
- Simultaneous events:
  - A release and a fill-completion on the other buffer in the same cycle are both applied.
  - The WAIT_BUF decision uses next-cycle full flags, so a same-cycle release goes straight to LOAD_ROW.
- Abort: load_en = 0 in any state except IDLE forces IDLE next cycle.
  - Clears full flags, counters, row_idx and wr_sel/rd_sel.
  - Drops mem_en; in-flight read data is discarded.
  - No done pulse is issued.
  - a_data is retained.
- Reset mid-operation: same as the reset values above, immediately (asynchronous).
- No new mem_en is issued in WAIT_BUF, DONE or IDLE.

Decomposition:
- Shared package (matrix_pkg): state encodings, DATA_W/ADDR_W defaults, A_WORDS/ROW_WORDS/N_ROWS, base addresses.
- One sub-module: row_pingpong_buf. It holds the two row buffers with write port (wr_sel, word index, data, we) and read port, plus the full flags, wr_sel/rd_sel and the release logic.

Test Plan:
1. Reset, mem_ry = 1, memory word k = k. Assert load_en and load_A_en. -> mem_en at addresses 0..3; load_A_done one cycle at 5 cycles after the first mem_en; a_data = {3,2,1,0}.
2. Continue with no row_finish. -> Row 0 from addresses 16..22, then row 1 from 23..29. load_done pulses twice. row_valid = 1, row_data = words 16..22. State is WAIT_BUF with mem_en = 0.
3. Pulse row_finish. -> row_data switches to words 23..29. Next cycle the row 2 fetch starts at address 30.
4. mem_ry toggled 1,0 through a row. -> Addresses held while stalled; no word skipped or duplicated; load_done only after 7 captures.
5. Full frame with row_finish every 30 cycles. -> Exactly 28 load_done pulses; last row read at addresses 205..211; state DONE; IDLE after load_en drops.
6. Drop load_en midway through row 5. -> mem_en low next cycle, row_valid = 0, no load_done. A restart loads row 0 from address 16.
